// File: rtl/mario_motion_ctrl_pkg.sv
// mario_pkg: types and screen constants shared by the player motion controller.
//   sprite_t    : sprite-ROM select code driven to the pixel pipeline (0..5)
//   state_t     : motion state machine encoding
//   X_MIN/X_MAX : horizontal clamp limits for the sprite left edge
//   Y_GROUND    : sprite top edge while standing on the ground
//   sprite_code : maps state / walk phase / facing onto a sprite code
package mario_pkg;

    typedef enum logic [2:0] {
        SPR_IDLE_R = 3'd0,
        SPR_IDLE_L = 3'd1,
        SPR_WALK_R = 3'd2,
        SPR_WALK_L = 3'd3,
        SPR_JUMP_R = 3'd4,
        SPR_JUMP_L = 3'd5
    } sprite_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_AIR  = 2'd2,
        ST_LAND = 2'd3
    } state_t;

    localparam int unsigned CHAR_WIDTH   = 32;
    localparam int unsigned CHAR_HEIGHT  = 32;
    // Right edge of the play field and the ground line the sprite stands on.
    localparam int unsigned FIELD_X_END  = 734;
    localparam int unsigned GROUND_LINE  = 492;
    localparam int unsigned X_MIN        = 143;
    localparam int unsigned X_MAX        = FIELD_X_END - CHAR_WIDTH;   // 702
    localparam int unsigned Y_GROUND     = GROUND_LINE - CHAR_HEIGHT;  // 460

    function automatic sprite_t sprite_code(input state_t st,
                                            input logic   walk_phase,
                                            input logic   face_left);
        sprite_t code;
        if (st == ST_AIR)
            code = face_left ? SPR_JUMP_L : SPR_JUMP_R;
        else if (st == ST_WALK && walk_phase)
            code = face_left ? SPR_WALK_L : SPR_WALK_R;
        else
            code = face_left ? SPR_IDLE_L : SPR_IDLE_R;
        return code;
    endfunction

endpackage

// File: rtl/mario_motion_ctrl_if.sv
// mario_motion_ctrl_if: button inputs and sprite position/select outputs of the
// player motion controller.
//   master : button source / sprite consumer (drives btn_*, reads outputs)
//   slave  : the motion controller (reads btn_*, drives outputs)
//   btn_left/btn_right/btn_jump : debounced level buttons
//   pos_x/pos_y  : sprite left/top edge in screen pixels
//   sprite_sel   : sprite ROM select (mario_pkg::sprite_t encoding)
//   facing_left  : current facing direction
//   airborne     : high while the character is in the air
interface mario_motion_ctrl_if;

    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [2:0] sprite_sel;
    logic       facing_left;
    logic       airborne;

    modport master (
        output btn_left, btn_right, btn_jump,
        input  pos_x, pos_y, sprite_sel, facing_left, airborne
    );

    modport slave (
        input  btn_left, btn_right, btn_jump,
        output pos_x, pos_y, sprite_sel, facing_left, airborne
    );

endinterface

// File: rtl/mario_motion_ctrl_tick_prescaler.sv
// tick_prescaler: free-running divider that pulses tick on the last cycle of
// every DIV-cycle window while en is high; the count restarts from zero
// whenever en drops.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   en   : count enable (counter held at zero when low)
//   tick : one-cycle pulse on the wrap cycle (combinational from the count)
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == W'(DIV - 1)) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mario_motion_ctrl.sv
// mario_motion_ctrl: turns the left/right/jump buttons into a registered sprite
// position and sprite-ROM select code for the VGA pixel pipeline.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : mario_motion_ctrl_if.slave (buttons in; pos_x, pos_y, sprite_sel,
//         facing_left, airborne out, all registered)
module mario_motion_ctrl
    import mario_pkg::*;
#(
    parameter int unsigned MOVE_DIV      = 500000,
    parameter int unsigned GRAV_DIV      = 1000000,
    parameter int unsigned JUMP_COOLDOWN = 1000000,
    parameter int unsigned WALK_FRAMES   = 5,
    parameter int unsigned V_INIT        = 15,
    parameter int unsigned X_INIT        = 300,
    parameter int unsigned Y_GROUND      = mario_pkg::Y_GROUND,
    parameter int unsigned X_MIN         = mario_pkg::X_MIN,
    parameter int unsigned X_MAX         = mario_pkg::X_MAX
) (
    input  logic               clk,
    input  logic               rst,
    mario_motion_ctrl_if.slave bus
);

    localparam int unsigned CW = (JUMP_COOLDOWN > 1) ? $clog2(JUMP_COOLDOWN) : 1;
    localparam int unsigned WW = (WALK_FRAMES > 1)   ? $clog2(WALK_FRAMES)   : 1;

    state_t             state_q, state_d;
    logic [9:0]         pos_x_q, pos_x_d;
    logic [9:0]         pos_y_q, pos_y_d;
    logic signed [6:0]  vy_q, vy_d;
    logic [WW-1:0]      walk_cnt_q, walk_cnt_d;
    logic               walk_phase_q, walk_phase_d;
    logic [CW-1:0]      cool_cnt_q, cool_cnt_d;
    logic               facing_q, facing_d;
    logic               airborne_q, airborne_d;
    sprite_t            sprite_q, sprite_d;

    logic               dir_held;
    logic               move_tick;
    logic               grav_tick;
    logic               in_air;
    logic [10:0]        ny;

    assign dir_held = bus.btn_left | bus.btn_right;
    assign in_air   = (state_q == ST_AIR);

    tick_prescaler #(.DIV(MOVE_DIV)) u_move_div (
        .clk  (clk),
        .rst  (rst),
        .en   (dir_held),
        .tick (move_tick)
    );

    tick_prescaler #(.DIV(GRAV_DIV)) u_grav_div (
        .clk  (clk),
        .rst  (rst),
        .en   (in_air),
        .tick (grav_tick)
    );

    // Candidate height after one gravity tick; bit 10 is the sign.
    assign ny = {1'b0, pos_y_q} + {{4{vy_q[6]}}, vy_q};

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        vy_d         = vy_q;
        walk_cnt_d   = walk_cnt_q;
        walk_phase_d = walk_phase_q;
        cool_cnt_d   = '0;
        facing_d     = facing_q;

        // Left wins when both are held.
        if (bus.btn_left)       facing_d = 1'b1;
        else if (bus.btn_right) facing_d = 1'b0;

        if (move_tick) begin
            if (bus.btn_left)
                pos_x_d = (pos_x_q <= 10'(X_MIN)) ? 10'(X_MIN) : pos_x_q - 10'd1;
            else
                pos_x_d = (pos_x_q >= 10'(X_MAX)) ? 10'(X_MAX) : pos_x_q + 10'd1;
        end

        case (state_q)
            ST_IDLE, ST_WALK: begin
                if (bus.btn_jump) begin
                    state_d = ST_AIR;
                    pos_y_d = 10'(Y_GROUND - V_INIT);
                    vy_d    = 7'sd0 - 7'(V_INIT);
                end else if (dir_held) begin
                    state_d = ST_WALK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AIR: begin
                if (grav_tick) begin
                    if (!ny[10] && ny >= 11'(Y_GROUND)) begin
                        pos_y_d = 10'(Y_GROUND);
                        vy_d    = 7'sd0;
                        state_d = ST_LAND;
                    end else begin
                        pos_y_d = ny[10] ? 10'd0 : ny[9:0];
                        if (vy_q != 7'sd63) vy_d = vy_q + 7'sd1;
                    end
                end
            end
            ST_LAND: begin
                if (cool_cnt_q == CW'(JUMP_COOLDOWN - 1))
                    state_d = dir_held ? ST_WALK : ST_IDLE;
                else
                    cool_cnt_d = cool_cnt_q + CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Walk animation only runs while staying in (or entering) WALK, so a
        // step taken on the leaving edge does not leave a stale phase behind.
        if (state_d != ST_WALK) begin
            walk_cnt_d   = '0;
            walk_phase_d = 1'b0;
        end else if (move_tick) begin
            if (walk_cnt_q == WW'(WALK_FRAMES - 1)) begin
                walk_cnt_d   = '0;
                walk_phase_d = ~walk_phase_q;
            end else begin
                walk_cnt_d = walk_cnt_q + WW'(1);
            end
        end

        airborne_d = (state_d == ST_AIR);
        sprite_d   = sprite_code(state_d, walk_phase_d, facing_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pos_x_q      <= 10'(X_INIT);
            pos_y_q      <= 10'(Y_GROUND);
            vy_q         <= 7'sd0;
            walk_cnt_q   <= '0;
            walk_phase_q <= 1'b0;
            cool_cnt_q   <= '0;
            facing_q     <= 1'b0;
            airborne_q   <= 1'b0;
            sprite_q     <= SPR_IDLE_R;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            vy_q         <= vy_d;
            walk_cnt_q   <= walk_cnt_d;
            walk_phase_q <= walk_phase_d;
            cool_cnt_q   <= cool_cnt_d;
            facing_q     <= facing_d;
            airborne_q   <= airborne_d;
            sprite_q     <= sprite_d;
        end
    end

    assign bus.pos_x       = pos_x_q;
    assign bus.pos_y       = pos_y_q;
    assign bus.sprite_sel  = sprite_q;
    assign bus.facing_left = facing_q;
    assign bus.airborne    = airborne_q;

endmodule
